// File: rtl/alu_result_stage.sv
// alu_result_stage: registered 2-entry skid FIFO behind the ALU.
// Screens illegal ops on push, commits flags/err/retire count on pop.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready ALU-side handshake (in_ready is registered)
//   in_result, in_b   ALU result and operand B (div/mod-by-zero check)
//   in_sel            ALU opcode that produced in_result
//   in_rd, in_wb_en   destination register and write enable
//   in_flag_en        commit the flags on retire
//   in_Z/O/Ca/Neg     ALU flags
//   out_valid/ready   writeback-side handshake
//   out_result/rd     head entry payload
//   out_wb_en/err     head write enable after screening, illegal marker
//   flag_Z/O/Ca/Neg   architectural flag register
//   err_sticky/clr    sticky illegal-op indicator and its clear
//   retired_cnt       wrapping count of retired entries
module alu_result_stage #(
    parameter int N      = 6,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_result,
    input  logic [N-1:0]      in_b,
    input  logic [3:0]        in_sel,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wb_en,
    input  logic              in_flag_en,
    input  logic              in_Z,
    input  logic              in_O,
    input  logic              in_Ca,
    input  logic              in_Neg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wb_en,
    output logic              out_err,
    output logic              flag_Z,
    output logic              flag_O,
    output logic              flag_Ca,
    output logic              flag_Neg,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef struct packed {
        logic [N-1:0]      result;
        logic [REG_AW-1:0] rd;
        logic              wb_en;
        logic              flag_en;
        logic              err;
        logic              z;
        logic              o;
        logic              ca;
        logic              neg;
    } entry_t;

    entry_t             mem_q [2];
    entry_t             mem_d [2];
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [3:0]         flags_q, flags_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    entry_t             head;
    entry_t             new_entry;
    logic               illegal;
    logic               push;
    logic               pop;

    assign head = mem_q[rd_ptr_q];
    assign push = in_valid & ready_q;
    assign pop  = valid_q & out_ready;

    // Div/mod by zero, or an opcode beyond the defined range.
    always_comb begin
        illegal = (((in_sel == 4'b0011) || (in_sel == 4'b0100))
                   && (in_b == '0))
                  || (in_sel > 4'b1010);
    end

    always_comb begin
        new_entry         = '0;
        new_entry.result  = in_result;
        new_entry.rd      = in_rd;
        new_entry.wb_en   = in_wb_en & ~illegal;
        new_entry.flag_en = in_flag_en & ~illegal;
        new_entry.err     = illegal;
        new_entry.z       = in_Z;
        new_entry.o       = in_O;
        new_entry.ca      = in_Ca;
        new_entry.neg     = in_Neg;
    end

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        valid_d = (count_d != 2'd0);
        ready_d = (count_d != 2'd2);
    end

    // Committed state moves only on retire, so it follows program order.
    always_comb begin
        flags_d = flags_q;
        err_d   = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (pop) begin
            if (head.flag_en) begin
                flags_d = {head.z, head.o, head.ca, head.neg};
            end
            if (head.err) begin
                err_d = 1'b1;
            end
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            flags_q  <= 4'd0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = valid_q;
    assign out_result  = head.result;
    assign out_rd      = head.rd;
    assign out_wb_en   = head.wb_en;
    assign out_err     = head.err;
    assign flag_Z      = flags_q[3];
    assign flag_O      = flags_q[2];
    assign flag_Ca     = flags_q[1];
    assign flag_Neg    = flags_q[0];
    assign err_sticky  = err_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed bench for alu_result_stage.
// Two instances share stimulus: default counter width and a 4-bit one.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  in_result;
    logic [5:0]  in_b;
    logic [3:0]  in_sel;
    logic [3:0]  in_rd;
    logic        in_wb_en, in_flag_en;
    logic        in_Z, in_O, in_Ca, in_Neg;
    logic        out_ready;
    logic        err_clr;

    logic        in_ready, out_valid, out_wb_en, out_err;
    logic [5:0]  out_result;
    logic [3:0]  out_rd;
    logic        flag_Z, flag_O, flag_Ca, flag_Neg, err_sticky;
    logic [15:0] retired_cnt;

    logic        w_in_ready, w_out_valid, w_out_wb_en, w_out_err;
    logic [5:0]  w_out_result;
    logic [3:0]  w_out_rd;
    logic        w_flag_Z, w_flag_O, w_flag_Ca, w_flag_Neg, w_err_sticky;
    logic [3:0]  w_retired_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.N(6), .REG_AW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_b(in_b), .in_sel(in_sel),
        .in_rd(in_rd), .in_wb_en(in_wb_en), .in_flag_en(in_flag_en),
        .in_Z(in_Z), .in_O(in_O), .in_Ca(in_Ca), .in_Neg(in_Neg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_wb_en(out_wb_en), .out_err(out_err),
        .flag_Z(flag_Z), .flag_O(flag_O), .flag_Ca(flag_Ca),
        .flag_Neg(flag_Neg), .err_sticky(err_sticky),
        .err_clr(err_clr), .retired_cnt(retired_cnt)
    );

    alu_result_stage #(.N(6), .REG_AW(4), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_result(in_result), .in_b(in_b), .in_sel(in_sel),
        .in_rd(in_rd), .in_wb_en(in_wb_en), .in_flag_en(in_flag_en),
        .in_Z(in_Z), .in_O(in_O), .in_Ca(in_Ca), .in_Neg(in_Neg),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_result(w_out_result), .out_rd(w_out_rd),
        .out_wb_en(w_out_wb_en), .out_err(w_out_err),
        .flag_Z(w_flag_Z), .flag_O(w_flag_O), .flag_Ca(w_flag_Ca),
        .flag_Neg(w_flag_Neg), .err_sticky(w_err_sticky),
        .err_clr(err_clr), .retired_cnt(w_retired_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel,
                         input logic [5:0] res, input logic [5:0] b,
                         input logic [3:0] rd, input logic wb,
                         input logic fl, input logic [3:0] zocn);
        in_valid   = v;
        in_sel     = sel;
        in_result  = res;
        in_b       = b;
        in_rd      = rd;
        in_wb_en   = wb;
        in_flag_en = fl;
        {in_Z, in_O, in_Ca, in_Neg} = zocn;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt"}, 32'(retired_cnt), 32'(exp_cnt % 65536));
        chk({tag, "_cnt4"}, 32'(w_retired_cnt), 32'(exp_cnt % 16));
    endtask

    // Stream n incrementing results with out_ready=1 from an empty FIFO.
    task automatic stream(input string tag, input int n,
                          input logic [5:0] base);
        int pops = 0;
        int bad = 0;
        int stall = 0;
        out_ready = 1'b1;
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(1'b1, 4'b0000, base + 6'(i), 6'd1, 4'd1,
                             1'b1, 1'b0, 4'b0000);
            else in_valid = 1'b0;
            if (!in_ready) stall++;
            if (out_valid) begin
                if (out_result !== base + 6'(pops)) bad++;
                pops++;
            end
            step();
        end
        exp_cnt += pops;
        chk({tag, "_pops"}, 32'(pops), 32'(n));
        chk({tag, "_order"}, 32'(bad), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk_cnt(tag);
    endtask

    initial begin
        logic [5:0] got [$];
        int         cyc;
        rst       = 1'b1;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        drive(1'b0, 4'd0, 6'd0, 6'd0, 4'd0, 1'b0, 1'b0, 4'b0000);
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_flags", 32'({flag_Z, flag_O, flag_Ca, flag_Neg}), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk_cnt("rst");

        // Single op
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 6'd9, 6'd2, 4'd3, 1'b1, 1'b1, 4'b0010);
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_result", 32'(out_result), 32'd9);
        chk("single_rd", 32'(out_rd), 32'd3);
        chk("single_wb", 32'(out_wb_en), 32'd1);
        chk("single_err", 32'(out_err), 32'd0);
        step();
        exp_cnt++;
        chk("single_ca", 32'(flag_Ca), 32'd1);
        chk("single_z", 32'(flag_Z), 32'd0);
        chk("single_empty", 32'(out_valid), 32'd0);
        chk_cnt("single");

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 6'd1, 6'd1, 4'd2, 1'b1, 1'b0, 4'b0000);
        step();
        chk("bp_ready1", 32'(in_ready), 32'd1);
        in_result = 6'd2;
        step();
        chk("bp_ready2", 32'(in_ready), 32'd0);
        in_result = 6'd3;
        step();
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_head", 32'(out_result), 32'd1);
        out_ready = 1'b1;
        cyc = 0;
        while (got.size() < 3 && cyc < 10) begin
            logic drop;
            drop = in_valid & in_ready;
            if (out_valid) got.push_back(out_result);
            step();
            if (drop) in_valid = 1'b0;
            cyc++;
        end
        exp_cnt += 3;
        chk("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size(); i++)
            chk("bp_order", 32'(got[i]), 32'(i + 1));
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk_cnt("bp");

        stream("stream", 20, 6'd10);

        // Illegal: div by zero
        drive(1'b1, 4'b0011, 6'd5, 6'd0, 4'd4, 1'b1, 1'b1, 4'b1101);
        step();
        in_valid = 1'b0;
        chk("div0_wb", 32'(out_wb_en), 32'd0);
        chk("div0_err", 32'(out_err), 32'd1);
        chk("div0_result", 32'(out_result), 32'd5);
        chk("div0_noflag_push", 32'(err_sticky), 32'd0);
        step();
        exp_cnt++;
        chk("div0_flags", 32'({flag_Z, flag_O, flag_Ca, flag_Neg}),
            32'b0010);
        chk("div0_sticky", 32'(err_sticky), 32'd1);

        // Illegal: undefined opcode, retired alongside err_clr
        drive(1'b1, 4'b1111, 6'd7, 6'd3, 4'd5, 1'b1, 1'b1, 4'b1111);
        step();
        in_valid = 1'b0;
        chk("undef_wb", 32'(out_wb_en), 32'd0);
        chk("undef_err", 32'(out_err), 32'd1);
        err_clr = 1'b1;
        step();
        exp_cnt++;
        chk("setclr_sticky", 32'(err_sticky), 32'd1);
        chk("undef_flags", 32'({flag_Z, flag_O, flag_Ca, flag_Neg}),
            32'b0010);
        step();
        err_clr = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 32'd0);

        // Boundary: sel=1010 with b=0 is legal
        drive(1'b1, 4'b1010, 6'd33, 6'd0, 4'd6, 1'b1, 1'b1, 4'b0001);
        step();
        in_valid = 1'b0;
        chk("sel10_err", 32'(out_err), 32'd0);
        chk("sel10_wb", 32'(out_wb_en), 32'd1);
        step();
        exp_cnt++;
        chk("sel10_flags", 32'({flag_Z, flag_O, flag_Ca, flag_Neg}),
            32'b0001);
        chk("sel10_sticky", 32'(err_sticky), 32'd0);
        chk_cnt("illegal");

        // Boundary: sel=1011 is illegal; sets sticky before reset test
        drive(1'b1, 4'b1011, 6'd2, 6'd1, 4'd1, 1'b1, 1'b1, 4'b1000);
        step();
        in_valid = 1'b0;
        chk("sel11_err", 32'(out_err), 32'd1);
        step();
        chk("sel11_sticky", 32'(err_sticky), 32'd1);
        chk("sel11_neg", 32'(flag_Neg), 32'd1);

        // Reset mid-operation with full FIFO
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 6'd40, 6'd1, 4'd1, 1'b1, 1'b1, 4'b1111);
        step();
        step();
        chk("full_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        err_clr = 1'b0;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_cnt = 0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_flags", 32'({flag_Z, flag_O, flag_Ca, flag_Neg}),
            32'd0);
        chk("mid_rst_err", 32'(err_sticky), 32'd0);
        chk("mid_rst_result", 32'(out_result), 32'd0);
        chk_cnt("mid_rst");
        step();
        chk("mid_rst_stays_empty", 32'(out_valid), 32'd0);

        // Counter wrap on the 4-bit instance
        stream("wrap", 17, 6'd50);
        chk("wrap_cnt4_is_1", 32'(w_retired_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
